// File: rtl/bus_rr_xbar_pkg.sv
// Shared types for the round-robin bus crossbar: the response-tracker entry
// and the index-width helper used by the crossbar and its tracker FIFO.
package bus_rr_xbar_pkg;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index fields are sized for the largest supported host/device counts so a
  // single packed entry type serves every configuration up to these limits.
  localparam int MaxHosts   = 16;
  localparam int MaxDevices = 16;
  localparam int HostIdxW   = idx_w(MaxHosts);
  localparam int DevIdxW    = idx_w(MaxDevices);

  typedef logic [HostIdxW-1:0] host_idx_t;
  typedef logic [DevIdxW-1:0]  dev_idx_t;

  typedef struct packed {
    host_idx_t host;
    dev_idx_t  dev;
    logic      decerr;
  } resp_entry_t;

endpackage

// File: rtl/bus_rr_xbar_if.sv
// Host-side and device-side bus bundle of the crossbar. The crossbar uses the
// slave view; the surrounding system (hosts and devices) uses the master view.
interface bus_rr_xbar_if #(
  parameter int NrHosts      = 2,
  parameter int NrDevices    = 3,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
);

  logic [NrHosts-1:0]                      host_req;
  logic [NrHosts-1:0]                      host_gnt;
  logic [NrHosts-1:0][AddressWidth-1:0]    host_addr;
  logic [NrHosts-1:0]                      host_we;
  logic [NrHosts-1:0][DataWidth/8-1:0]     host_be;
  logic [NrHosts-1:0][DataWidth-1:0]       host_wdata;
  logic [NrHosts-1:0]                      host_rvalid;
  logic [NrHosts-1:0][DataWidth-1:0]       host_rdata;
  logic [NrHosts-1:0]                      host_err;

  logic [NrDevices-1:0]                    device_req;
  logic [NrDevices-1:0][AddressWidth-1:0]  device_addr;
  logic [NrDevices-1:0]                    device_we;
  logic [NrDevices-1:0][DataWidth/8-1:0]   device_be;
  logic [NrDevices-1:0][DataWidth-1:0]     device_wdata;
  logic [NrDevices-1:0]                    device_rvalid;
  logic [NrDevices-1:0][DataWidth-1:0]     device_rdata;
  logic [NrDevices-1:0]                    device_err;

  modport slave (
    input  host_req, host_addr, host_we, host_be, host_wdata,
    input  device_rvalid, device_rdata, device_err,
    output host_gnt, host_rvalid, host_rdata, host_err,
    output device_req, device_addr, device_we, device_be, device_wdata
  );

  modport master (
    output host_req, host_addr, host_we, host_be, host_wdata,
    output device_rvalid, device_rdata, device_err,
    input  host_gnt, host_rvalid, host_rdata, host_err,
    input  device_req, device_addr, device_we, device_be, device_wdata
  );

endinterface

// File: rtl/bus_rr_xbar_resp_fifo.sv
// In-order tracker of granted-but-unanswered transactions. The head entry
// tells the crossbar which device must answer next and which host to route to.
module bus_rr_xbar_resp_fifo
  import bus_rr_xbar_pkg::*;
#(
  parameter int Depth = 4,
  localparam int CntW = $clog2(Depth + 1),
  localparam int PtrW = idx_w(Depth)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  resp_entry_t     entry_i,
  input  logic            pop_i,
  output resp_entry_t     head_o,
  output logic [CntW-1:0] count_o,
  output logic            empty_o,
  output logic            full_o
);

  resp_entry_t     r_mem [Depth];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) begin
        r_wr_ptr <= (r_wr_ptr == PtrW'(Depth - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (pop_i) begin
        r_rd_ptr <= (r_rd_ptr == PtrW'(Depth - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      unique case ({push_i, pop_i})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage carries no reset: the count alone decides which slots are live.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      r_mem[r_wr_ptr] <= entry_i;
    end
  end

  assign head_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;
  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == CntW'(Depth));

endmodule

// File: rtl/bus_rr_xbar.sv
// Round-robin N-host to M-device bus crossbar with address decode, decode-error
// responses, an in-order response tracker and a sticky protocol-violation flag.
module bus_rr_xbar
  import bus_rr_xbar_pkg::*;
#(
  parameter int NrHosts        = 2,
  parameter int NrDevices      = 3,
  parameter int DataWidth      = 32,
  parameter int AddressWidth   = 32,
  parameter int MaxOutstanding = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  bus_rr_xbar_if.slave                           bus,
  input  logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_base,
  input  logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_mask,
  output logic                                   protocol_err_o
);

  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int BeW  = DataWidth / 8;

  host_idx_t             r_rr_ptr;
  logic                  r_protocol_err;

  int                    w_scan;
  logic                  w_any_req;
  host_idx_t             w_winner;
  logic                  w_gnt;
  logic [AddressWidth-1:0] w_addr;
  logic                  w_we;
  logic [BeW-1:0]        w_be;
  logic [DataWidth-1:0]  w_wdata;
  logic                  w_dev_hit;
  dev_idx_t              w_dev;

  resp_entry_t           w_push_entry;
  resp_entry_t           w_head;
  logic [CntW-1:0]       w_count;
  logic                  w_empty;
  logic                  w_full_unused;
  logic                  w_pop;
  logic                  w_head_rvalid;
  logic [DataWidth-1:0]  w_head_rdata;
  logic                  w_head_err;
  logic                  w_spurious;

  // Arbitration: first requester at or after the pointer, judged on the
  // registered tracker count so a same-cycle pop never frees a slot early.
  always_comb begin
    w_scan    = 0;
    w_any_req = 1'b0;
    w_winner  = '0;
    for (int i = 0; i < NrHosts; i++) begin
      w_scan = (int'(r_rr_ptr) + i) % NrHosts;
      if (!w_any_req && bus.host_req[w_scan]) begin
        w_any_req = 1'b1;
        w_winner  = host_idx_t'(w_scan);
      end
    end
  end

  assign w_gnt = w_any_req && !rst_i && (w_count < CntW'(MaxOutstanding));

  always_comb begin
    w_addr  = '0;
    w_we    = 1'b0;
    w_be    = '0;
    w_wdata = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (w_winner == host_idx_t'(h)) begin
        w_addr  = bus.host_addr[h];
        w_we    = bus.host_we[h];
        w_be    = bus.host_be[h];
        w_wdata = bus.host_wdata[h];
      end
      bus.host_gnt[h] = w_gnt && (w_winner == host_idx_t'(h));
    end
  end

  // Decode: the lowest-index matching region wins; no match is a decode error.
  always_comb begin
    w_dev_hit = 1'b0;
    w_dev     = '0;
    for (int d = 0; d < NrDevices; d++) begin
      if (!w_dev_hit && ((w_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d])) begin
        w_dev_hit = 1'b1;
        w_dev     = dev_idx_t'(d);
      end
    end
  end

  always_comb begin
    for (int d = 0; d < NrDevices; d++) begin
      bus.device_req[d]   = w_gnt && w_dev_hit && (w_dev == dev_idx_t'(d));
      bus.device_addr[d]  = w_gnt ? w_addr  : '0;
      bus.device_we[d]    = w_gnt ? w_we    : 1'b0;
      bus.device_be[d]    = w_gnt ? w_be    : '0;
      bus.device_wdata[d] = w_gnt ? w_wdata : '0;
    end
  end

  assign w_push_entry = '{host: w_winner, dev: w_dev, decerr: !w_dev_hit};

  bus_rr_xbar_resp_fifo #(
    .Depth (MaxOutstanding)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_gnt),
    .entry_i (w_push_entry),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .count_o (w_count),
    .empty_o (w_empty),
    .full_o  (w_full_unused)
  );

  // Response path: only the device named by the head entry may retire it.
  always_comb begin
    w_head_rvalid = 1'b0;
    w_head_rdata  = '0;
    w_head_err    = 1'b0;
    w_spurious    = 1'b0;
    for (int d = 0; d < NrDevices; d++) begin
      if (w_head.dev == dev_idx_t'(d)) begin
        w_head_rvalid = bus.device_rvalid[d];
        w_head_rdata  = bus.device_rdata[d];
        w_head_err    = bus.device_err[d];
      end
      if (bus.device_rvalid[d] && (w_empty || w_head.decerr || (w_head.dev != dev_idx_t'(d)))) begin
        w_spurious = 1'b1;
      end
    end
  end

  assign w_pop = !w_empty && (w_head.decerr || w_head_rvalid);

  always_comb begin
    bus.host_rvalid = '0;
    bus.host_rdata  = '0;
    bus.host_err    = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (w_pop && (w_head.host == host_idx_t'(h))) begin
        bus.host_rvalid[h] = 1'b1;
        bus.host_rdata[h]  = w_head.decerr ? '0 : w_head_rdata;
        bus.host_err[h]    = w_head.decerr | w_head_err;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr       <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      if (w_gnt) begin
        r_rr_ptr <= (int'(w_winner) == NrHosts - 1) ? '0 : w_winner + 1'b1;
      end
      if (w_spurious) begin
        r_protocol_err <= 1'b1;
      end
    end
  end

  assign protocol_err_o = r_protocol_err;

endmodule
